// File: rtl/seq_mult4_ctrl_pkg.sv
// rtl/seq_mult4_ctrl_pkg.sv - shared state encodings and 7-segment glyph table
package seq_mult4_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-low segments, bit0=a .. bit6=g; b and d are lowercase glyphs.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seq_mult4_ctrl_if.sv
// rtl/seq_mult4_ctrl_if.sv - DE2 board pins seen by the multiplier controller
interface seq_mult4_ctrl_if;

    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [17:0] LEDR;

    modport master (output KEY, output SW, input HEX0, input HEX1, input LEDR);
    modport slave  (input KEY, input SW, output HEX0, output HEX1, output LEDR);

endinterface

// File: rtl/seq_mult4_ctrl_nibble_adder.sv
// rtl/seq_mult4_ctrl_nibble_adder.sv - combinational 4-bit ripple-carry adder
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];

endmodule

// File: rtl/seq_mult4_ctrl.sv
// rtl/seq_mult4_ctrl.sv - sequential 4x4 shift-and-add multiplier with one shared adder
module seq_mult4_ctrl #(
    parameter int N_BITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLOCK_50,
    seq_mult4_ctrl_if.slave       bus
);

    import seq_mult4_ctrl_pkg::*;

    localparam int CW = $clog2(N_BITS);

    logic                   w_rst_n;
    logic                   w_start;
    logic                   w_unused;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_key_prev;

    state_t                 r_state, w_state_nxt;
    logic [N_BITS-1:0]      r_a, r_q, r_m;
    logic [N_BITS-1:0]      w_a_nxt, w_q_nxt, w_m_nxt;
    logic [CW-1:0]          r_count, w_count_nxt;
    logic [2*N_BITS-1:0]    r_product, w_product_nxt;

    logic [N_BITS-1:0]      w_addend;
    logic [N_BITS-1:0]      w_sum;
    logic                   w_cout;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        hex7seg = SEG_TABLE[v];
    endfunction

    assign w_rst_n  = bus.KEY[0];
    assign w_unused = ^{bus.KEY[3:2], bus.SW[13:4]};

    // Press is a high-to-low transition of the synchronized button.
    assign w_start = r_key_prev & ~r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync     <= '0;
            r_key_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], bus.KEY[1]};
            r_key_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_addend = r_q[0] ? r_m : '0;

    nibble_adder u_adder (
        .a    (r_a),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_q       <= w_q_nxt;
            r_m       <= w_m_nxt;
            r_count   <= w_count_nxt;
            r_product <= w_product_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_q_nxt       = r_q;
        w_m_nxt       = r_m;
        w_count_nxt   = r_count;
        w_product_nxt = r_product;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_m_nxt     = bus.SW[17:14];
                    w_q_nxt     = bus.SW[3:0];
                    w_a_nxt     = '0;
                    w_count_nxt = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Carry-out becomes the new MSB as {A,Q} shifts right.
                {w_a_nxt, w_q_nxt} = {w_cout, w_sum, r_q[N_BITS-1:1]};
                w_count_nxt        = r_count + 1'b1;
                if (r_count == CW'(N_BITS - 1)) begin
                    w_product_nxt = {w_cout, w_sum, r_q[N_BITS-1:1]};
                    w_state_nxt   = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.LEDR = {(r_state == ST_RUN), (r_state == ST_DONE), 8'b0, r_product};
    assign bus.HEX0 = hex7seg(r_product[3:0]);
    assign bus.HEX1 = hex7seg(r_product[7:4]);

endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// tb/tb_seq_mult4_ctrl.sv - self-checking bench for the sequential multiplier controller
module tb_seq_mult4_ctrl;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    seq_mult4_ctrl_if bus ();

    seq_mult4_ctrl dut (
        .CLOCK_50 (CLOCK_50),
        .bus      (bus.slave)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] last_prod = 8'h00;
    logic [6:0] glyph [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input logic [7:0] exp);
        chk("product", {24'b0, bus.LEDR[7:0]}, {24'b0, exp});
        chk("hex0", {25'b0, bus.HEX0}, {25'b0, glyph[exp[3:0]]});
        chk("hex1", {25'b0, bus.HEX1}, {25'b0, glyph[exp[7:4]]});
        chk("done", {31'b0, bus.LEDR[16]}, 32'd1);
        chk("busy_after", {31'b0, bus.LEDR[17]}, 32'd0);
    endtask

    // Loads m,q, presses start and follows the run; chg also clears SW
    // and re-presses the button while the multiplier is busy.
    task automatic run_op(input logic [3:0] m, input logic [3:0] q, input bit chg);
        int         t;
        int         len;
        logic [7:0] exp;
        exp             = 8'(int'(m) * int'(q));
        bus.SW          = '0;
        bus.SW[17:14]   = m;
        bus.SW[3:0]     = q;
        @(negedge CLOCK_50);
        bus.KEY[1] = 1'b0;
        t = 0;
        while (bus.LEDR[17] !== 1'b1 && t < 12) begin
            @(negedge CLOCK_50);
            t++;
        end
        chk("start_seen", {31'b0, bus.LEDR[17]}, 32'd1);
        bus.KEY[1] = 1'b1;
        if (chg) bus.SW = '0;
        len = 0;
        while (bus.LEDR[17] === 1'b1 && len < 10) begin
            chk("run_prev_prod", {24'b0, bus.LEDR[7:0]}, {24'b0, last_prod});
            chk("run_done_low", {31'b0, bus.LEDR[16]}, 32'd0);
            len++;
            @(negedge CLOCK_50);
            if (chg && len == 1) bus.KEY[1] = 1'b0;
        end
        chk("busy_len", len, 32'd4);
        check_result(exp);
        last_prod  = exp;
        bus.KEY[1] = 1'b1;
        repeat (5) @(negedge CLOCK_50);
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        bus.KEY = 4'b1110;
        bus.SW  = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_ledr", {14'b0, bus.LEDR}, 32'd0);
        bus.KEY[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            chk("idle_ledr", {14'b0, bus.LEDR}, 32'd0);
            chk("idle_hex0", {25'b0, bus.HEX0}, {25'b0, 7'b1000000});
            chk("idle_hex1", {25'b0, bus.HEX1}, {25'b0, 7'b1000000});
        end

        run_op(4'hF, 4'hF, 1'b0);
        chk("e1_hex1", {25'b0, bus.HEX1}, {25'b0, 7'b0000110});
        chk("e1_hex0", {25'b0, bus.HEX0}, {25'b0, 7'b1111001});
        chk("e1_prod", {24'b0, bus.LEDR[7:0]}, 32'hE1);

        run_op(4'hA, 4'h3, 1'b1);
        chk("a3_prod", {24'b0, bus.LEDR[7:0]}, 32'h1E);

        run_op(4'h7, 4'h0, 1'b0);

        bus.SW        = '0;
        bus.SW[17:14] = 4'h9;
        bus.SW[3:0]   = 4'h9;
        @(negedge CLOCK_50);
        bus.KEY[1] = 1'b0;
        for (int t = 0; t < 12 && bus.LEDR[17] !== 1'b1; t++) @(negedge CLOCK_50);
        chk("rst_run_busy", {31'b0, bus.LEDR[17]}, 32'd1);
        @(negedge CLOCK_50);
        bus.KEY[0] = 1'b0;
        #1;
        chk("midrst_ledr", {14'b0, bus.LEDR}, 32'd0);
        chk("midrst_hex0", {25'b0, bus.HEX0}, {25'b0, 7'b1000000});
        chk("midrst_hex1", {25'b0, bus.HEX1}, {25'b0, 7'b1000000});
        bus.KEY[1] = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        bus.KEY[0] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("post_rst_idle", {14'b0, bus.LEDR}, 32'd0);
        last_prod = 8'h00;
        run_op(4'h9, 4'h9, 1'b0);
        chk("nine_sq", {24'b0, bus.LEDR[7:0]}, 32'h51);

        for (int i = 0; i < 20; i++) begin
            run_op(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
        end

        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                run_op(4'(m), 4'(q), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
